// File: rtl/lsu_pkg.sv
// minirv load/store unit shared definitions.
// funct3 codes, FSM states and byte strobe base patterns.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_e;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/data,
// access legality, and load byte/half extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic        bad,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store lanes and legality; unsigned variants are load-only
  always_comb begin
    wstrb    = '0;
    wdata_sh = '0;
    bad      = 1'b0;
    unique case (funct3)
      LSU_B, LSU_BU: begin
        wstrb    = 4'(STRB_B << off);
        wdata_sh = {4{wdata[7:0]}};
        bad      = we && (funct3 == LSU_BU);
      end
      LSU_H, LSU_HU: begin
        wstrb    = 4'(STRB_H << off);
        wdata_sh = {2{wdata[15:0]}};
        bad      = off[0] || (we && (funct3 == LSU_HU));
      end
      LSU_W: begin
        wstrb    = STRB_W;
        wdata_sh = wdata;
        bad      = (off != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    byte_sel  = rdata[7:0];
    half_sel  = off[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = rdata;
    unique case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    unique case (funct3)
      LSU_B:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU: rdata_ext = {24'd0, byte_sel};
      LSU_H:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      LSU_HU: rdata_ext = {16'd0, half_sel};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// minirv load/store control stage: execute -> memory -> writeback.
// Optional bus timeout enabled with `define LSU_TIMEOUT_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err
);

  lsu_state_e state, nxt;

  logic       a_we;
  logic [2:0] a_f3;
  logic [1:0] a_off;

  logic        in_idle;
  logic        al_we;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic        al_bad;
  logic [31:0] al_rdata;
  logic        tout;

  assign in_idle = (state == S_IDLE);
  assign al_we   = in_idle ? req_we : a_we;
  assign al_f3   = in_idle ? req_funct3 : a_f3;
  assign al_off  = in_idle ? req_addr[1:0] : a_off;

  lsu_align u_align (
    .we        (al_we),
    .funct3    (al_f3),
    .off       (al_off),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .wstrb     (al_wstrb),
    .wdata_sh  (al_wdata),
    .bad       (al_bad),
    .rdata_ext (al_rdata)
  );

  assign req_ready = in_idle;
  assign mem_req   = (state == S_REQ);
  assign mem_we    = (state == S_REQ) && a_we;
  assign rsp_valid = (state == S_RESP);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tcnt;
  logic             waiting;

  assign waiting = (state == S_REQ) || (state == S_WAIT_R);
  assign tout    = waiting && (tcnt == CNT_W'(TIMEOUT_CYC - 1));

  // Cycles spent in the current memory wait state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (nxt != state) begin
      tcnt <= '0;
    end else if (waiting) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign tout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (req_valid) nxt = al_bad ? S_RESP : S_REQ;
      S_REQ:
        if (mem_gnt)   nxt = a_we ? S_RESP : S_WAIT_R;
        else if (tout) nxt = S_RESP;
      S_WAIT_R:
        if (mem_rvalid || tout) nxt = S_RESP;
      S_RESP:
        if (rsp_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Request latch, memory-side outputs and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_we      <= 1'b0;
      a_f3      <= '0;
      a_off     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          a_we     <= req_we;
          a_f3     <= req_funct3;
          a_off    <= req_addr[1:0];
          rsp_rd   <= req_we ? 5'd0 : req_rd;
          rsp_data <= '0;
          rsp_err  <= al_bad;
          if (!al_bad) begin
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= req_we ? al_wdata : '0;
            mem_wstrb <= req_we ? al_wstrb : '0;
          end
        end
        S_REQ:
          if (!mem_gnt && tout) rsp_err <= 1'b1;
        S_WAIT_R:
          if (mem_rvalid)  rsp_data <= al_rdata;
          else if (tout)   rsp_err  <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus
// randomized ops checked against a lane-arithmetic model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit m_err(input bit we, input int f3, input int off);
    case (f3)
      0: return 0;
      1: return (off % 2) != 0;
      2: return off != 0;
      4: return we;
      5: return we || ((off % 2) != 0);
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] m_strb(input int f3, input int off);
    if (f3 == 0) return 32'(1 << off);
    if (f3 == 1) return 32'(3 << off);
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wd(input int f3, input int unsigned wd);
    if (f3 == 0) return (wd % 256) * 32'h01010101;
    if (f3 == 1) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input int f3, input int off,
                                       input int unsigned rd);
    int unsigned b, h;
    b = (rd >> (8 * off)) % 256;
    h = (rd >> (16 * (off / 2))) % 65536;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      5: return h;
      default: return rd;
    endcase
  endfunction

  task automatic do_op(input bit we, input int f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input int gd, input int rl, input logic [31:0] rdat,
                       input int rdy);
    bit e;
    int off;
    logic [31:0] xd, xa;
    off = int'(addr % 4);
    e   = m_err(we, f3, off);
    xd  = (e || we) ? 32'd0 : m_ld(f3, off, rdat);
    xa  = addr - 32'(off);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = 3'(f3);
    req_addr   = addr;
    req_wdata  = wd;
    req_rd     = rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (!e) begin
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(we));
      chk("mem_addr", mem_addr, xa);
      if (we) begin
        chk("mem_wstrb", 32'(mem_wstrb), m_strb(f3, off));
        chk("mem_wdata", mem_wdata, m_wd(f3, wd));
      end
      repeat (gd) begin
        @(negedge clk);
        chk("mem_req_hold", 32'(mem_req), 32'd1);
        chk("mem_addr_hold", mem_addr, xa);
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("mem_req_drop", 32'(mem_req), 32'd0);
      if (!we) begin
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        repeat (rl - 1) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = rdat;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end else begin
      chk("mem_req_err", 32'(mem_req), 32'd0);
    end
    for (int i = 0; i <= rdy; i++) begin
      if (i > 0) @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_err", 32'(rsp_err), 32'(e));
      chk("rsp_data", rsp_data, xd);
      chk("rsp_rd", 32'(rsp_rd), we ? 32'd0 : 32'(rd));
      chk("req_ready_resp", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int f3, gd;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_rd     = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    do_op(1, 0, 32'h80000003, 32'h000000A5, 5'd7, 2, 1, 0, 0);
    do_op(0, 0, 32'h80000002, 0, 5'd3, 0, 1, 32'h12F03456, 0);
    do_op(0, 4, 32'h80000002, 0, 5'd4, 1, 2, 32'h12F03456, 0);
    do_op(0, 1, 32'h80000002, 0, 5'd5, 0, 3, 32'h12F03456, 0);
    do_op(0, 2, 32'h80000006, 0, 5'd6, 0, 1, 0, 0);
    do_op(1, 1, 32'h80000002, 32'h0000BEEF, 5'd1, 0, 1, 0, 0);
    do_op(1, 2, 32'h80000010, 32'hDEADBEEF, 5'd2, 1, 1, 0, 0);
    do_op(0, 2, 32'h80000020, 0, 5'd9, 1, 2, 32'hCAFEF00D, 5);

    // reset while waiting for read data, then a stray rvalid
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h80000040; req_rd = 5'd11;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("wait_r_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      chk("stray_rvalid", 32'(rsp_valid), 32'd0);
      chk("stray_req_ready", 32'(req_ready), 32'd1);
    end

    // grant withheld
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h80000080; req_rd = 5'd12;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
    repeat (3) @(negedge clk);
    chk("to_still_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_data", rsp_data, 32'd0);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`else
    repeat (99) @(negedge clk);
    chk("nto_mem_req", 32'(mem_req), 32'd1);
    chk("nto_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    chk("after_wait_idle", 32'(req_ready), 32'd1);

    for (int n = 0; n < 200; n++) begin
      f3 = int'($urandom_range(0, 7));
      gd = int'($urandom_range(0, 2));
      do_op(1'($urandom_range(0, 1)), f3, $urandom, $urandom,
            5'($urandom), gd, int'($urandom_range(1, 3)), $urandom,
            int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the data memory port in the minirv core.
- Accepts one memory op per handshake from the execute stage and word-aligns the address.
- Builds byte strobes and shifted store data, issues a request/grant transaction to memory, then extracts and extends load data.
- Returns a result or error to writeback with a valid/ready handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 in this revision.
- TIMEOUT_CYC, 255, cycles allowed in a memory wait state before a bus error; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  execute stage presents an op
- req_ready  out  1  LSU can accept an op
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepts request this cycle
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address ({req_addr[31:2], 2'b00})
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte strobes
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- rsp_valid  out  1  result available to writeback
- rsp_ready  in  1  writeback accepts
- rsp_data  out  32  extended load data; 0 for stores
- rsp_rd  out  5  destination register; 0 for stores
- rsp_err  out  1  misaligned access or bus timeout

Behaviour:
- Reset values (rst_n low at posedge clk): state IDLE, req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0, timeout counter=0.
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all request fields.
  - Misaligned op (h/hu with addr[0]=1, w with addr[1:0]!=0) or illegal funct3: go to RESP with rsp_err=1, rsp_data=0; no memory access.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1; address, data and strobe outputs held stable until mem_gnt.
  - On gnt with store: go to RESP.
  - On gnt with load: go to WAIT_R.
  - mem_req drops the cycle after gnt.
- WAIT_R:
  - On mem_rvalid, capture extracted data into rsp_data and go to RESP.
  - An rvalid arriving in the same cycle as gnt is not supported; memory latency is at least 1 cycle.
- RESP:
  - rsp_valid=1; hold outputs until rsp_ready.
  - Then go to IDLE; req_ready goes to 1 the following cycle.
  - Throughput: one op per 3 cycles minimum for stores, 4 for loads; no overlap.
- Store lanes:
  - sb: wstrb = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - sh: wstrb = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - sw: wstrb = 1111.
- Load extract:
  - Select byte/half by addr[1:0].
  - b/h: sign-extend. bu/hu: zero-extend. w: pass through.
- req_ready=0 in every state except IDLE; req_valid is ignored there.
- Reset asserted mid-transaction: immediate return to IDLE next edge, mem_req dropped, pending response discarded.
- A late mem_rvalid arriving in IDLE is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle spent in REQ or WAIT_R; cleared on state entry.
  - Reaching TIMEOUT_CYC forces RESP with rsp_err=1, rsp_data=0, mem_req=0.
- Undefined:
  - No counter; the LSU waits indefinitely for gnt/rvalid.
  - rsp_err is driven only by misalignment or illegal funct3.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
  - State encoding constants.
  - Strobe base patterns.
- Sub-module lsu_align: purely combinational.
  - Store side: funct3 + addr[1:0] + wdata -> wstrb, shifted wdata, misalign flag.
  - Load side: funct3 + addr[1:0] + rdata -> extended result.
  - lsu_ctrl keeps the FSM, latching and handshakes.

Test Plan:
- sb addr 0x80000003, wdata 0x000000A5, gnt after 2 cycles -> mem_addr 0x80000000, wstrb 1000, wdata 0xA5A5A5A5, rsp_valid with rsp_err=0, rsp_data=0.
- lb addr 0x80000002, rdata 0x12F03456 -> rsp_data 0xFFFFFFF0; lbu same -> 0x000000F0; lh addr 0x80000002 -> 0x000012F0.
- lw addr 0x80000006 -> rsp_err=1 in RESP; mem_req never asserted.
- Load with rsp_ready held low 5 cycles -> rsp_valid, rsp_data and rsp_rd stable throughout; req_ready stays 0 until after acceptance.
- rst_n low while in WAIT_R -> next cycle IDLE, mem_req=0, rsp_valid=0; a subsequent stray mem_rvalid produces no response.
- With LSU_TIMEOUT_EN and TIMEOUT_CYC=4, gnt held low -> rsp_err=1 after 4 REQ cycles; without the macro -> still waiting at cycle 100.
